// File: rtl/mem_backend.sv
// mem_backend: single-port word memory behind a fixed-latency request FSM.
//
// A request is accepted in IDLE or DONE when req=1. The operands are latched,
// the block stays BUSY for LATENCY cycles and then performs the access.
// response rises on the completing edge and stays high in DONE until the next
// request is accepted.
//
// Handshake: req is a level strobe, sampled only in IDLE/DONE. While busy=1,
// req and all operand inputs are ignored. response=1 marks the completion of
// the last accepted request. For a read, out carries its data from the same
// edge. Holding req=1 in DONE restarts on the next edge, which gives one
// request per LATENCY+1 cycles.
//
// Parameters:
//   MEM_WORDS  number of 32-bit words stored (default 1024)
//   LATENCY    accept-to-response cycles, legal range 1..15 (default 4)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; memory contents are kept
//   req        request strobe
//   wr         1 = write, 0 = read
//   addr       word address
//   data       write data
//   response   1 = last accepted request complete
//   out        read data of the last completed read
//   busy       1 while a request is in flight
//   state_dbg  current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
//   err        (only with MEM_BACKEND_RANGE_CHECK_EN) the completed access
//              had addr >= MEM_WORDS
//
// Optional feature macro: MEM_BACKEND_RANGE_CHECK_EN. When it is defined,
// out-of-range accesses are flagged and suppressed. When it is not defined,
// addresses wrap modulo MEM_WORDS.

module mem_backend #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        response,
    output logic [31:0] out,
    output logic        busy,
    output logic [1:0]  state_dbg
`ifdef MEM_BACKEND_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       cnt, cnt_nxt;
    logic [31:0]      lat_addr, lat_data;
    logic             lat_wr;
    logic             resp_nxt, busy_nxt;
    logic [31:0]      out_nxt;
    logic             accept;
    logic             mem_we;
    logic [IDX_W-1:0] idx;

    // Contents start at zero and survive reset.
    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    assign idx       = IDX_W'(lat_addr % MEM_WORDS);
    assign state_dbg = state;
    assign accept    = (state == ST_IDLE || state == ST_DONE) && req;

`ifdef MEM_BACKEND_RANGE_CHECK_EN
    logic in_range;
    logic err_nxt;
    assign in_range = (lat_addr < 32'(MEM_WORDS));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (req) state_nxt = ST_BUSY;
            ST_BUSY:          if (cnt == 4'd0) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_nxt  = cnt;
        resp_nxt = response;
        busy_nxt = busy;
        out_nxt  = out;
        mem_we   = 1'b0;
`ifdef MEM_BACKEND_RANGE_CHECK_EN
        err_nxt  = err;
`endif
        if (accept) begin
            // The counter is loaded with LATENCY-1 because the completing
            // edge is itself one of the LATENCY cycles.
            cnt_nxt  = 4'(LATENCY - 1);
            resp_nxt = 1'b0;
            busy_nxt = 1'b1;
`ifdef MEM_BACKEND_RANGE_CHECK_EN
            err_nxt  = 1'b0;
`endif
        end else if (state == ST_BUSY) begin
            if (cnt != 4'd0) begin
                cnt_nxt = cnt - 4'd1;
            end else begin
                resp_nxt = 1'b1;
                busy_nxt = 1'b0;
`ifdef MEM_BACKEND_RANGE_CHECK_EN
                err_nxt = !in_range;
                mem_we  = lat_wr && in_range;
                if (!lat_wr) out_nxt = in_range ? mem[idx] : 32'h0;
`else
                mem_we = lat_wr;
                if (!lat_wr) out_nxt = mem[idx];
`endif
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            response <= 1'b0;
            busy     <= 1'b0;
            out      <= 32'h0;
            lat_addr <= 32'h0;
            lat_data <= 32'h0;
            lat_wr   <= 1'b0;
`ifdef MEM_BACKEND_RANGE_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            cnt      <= cnt_nxt;
            response <= resp_nxt;
            busy     <= busy_nxt;
            out      <= out_nxt;
`ifdef MEM_BACKEND_RANGE_CHECK_EN
            err      <= err_nxt;
`endif
            if (accept) begin
                lat_addr <= addr;
                lat_data <= data;
                lat_wr   <= wr;
            end
        end
    end

    // The memory has no reset. A reset that lands on the completing edge
    // must still abort the write, so rst gates the write enable here.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= lat_data;
        end
    end

endmodule
